// File: rtl/gpio_input_conditioner.sv
// GPIO input front-end: two-flop synchroniser, per-pin debounce counter,
// registered edge pulses and sticky pending bits feeding one interrupt line.
module gpio_input_conditioner #(
  parameter int G_NUM_PINS = 32,
  parameter int G_DB_BITS  = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  rst_i,
  input  logic [G_NUM_PINS-1:0] pins_i,
  input  logic [G_DB_BITS-1:0]  debounce_len_i,
  input  logic [G_NUM_PINS-1:0] rise_en_i,
  input  logic [G_NUM_PINS-1:0] fall_en_i,
  input  logic [G_NUM_PINS-1:0] irq_clr_i,
  output logic [G_NUM_PINS-1:0] pins_o,
  output logic [G_NUM_PINS-1:0] rise_o,
  output logic [G_NUM_PINS-1:0] fall_o,
  output logic [G_NUM_PINS-1:0] pending_o,
  output logic                  irq_o
);

  localparam logic [G_DB_BITS-1:0] DB_ONE = G_DB_BITS'(1);

  logic [G_NUM_PINS-1:0]                s1_q;
  logic [G_NUM_PINS-1:0]                s2_q;
  logic [G_NUM_PINS-1:0][G_DB_BITS-1:0] cnt_q;
  logic [G_NUM_PINS-1:0][G_DB_BITS-1:0] cnt_d;
  logic [G_NUM_PINS-1:0]                pins_q;
  logic [G_NUM_PINS-1:0]                pins_d;
  logic [G_NUM_PINS-1:0]                rise_q;
  logic [G_NUM_PINS-1:0]                rise_d;
  logic [G_NUM_PINS-1:0]                fall_q;
  logic [G_NUM_PINS-1:0]                fall_d;
  logic [G_NUM_PINS-1:0]                pending_q;
  logic [G_NUM_PINS-1:0]                pending_d;
  logic                                 irq_q;
  logic                                 irq_d;
  logic [G_DB_BITS-1:0]                 len_m1_s;

  // Debounce length of 0 behaves as 1, so the acceptance threshold never underflows.
  always_comb begin
    len_m1_s = '0;
    if (debounce_len_i == '0) begin
      len_m1_s = '0;
    end else begin
      len_m1_s = debounce_len_i - DB_ONE;
    end
  end

  // Per-pin counter and acceptance; edge pulses are produced on the accepting edge only.
  always_comb begin
    cnt_d  = cnt_q;
    pins_d = pins_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < G_NUM_PINS; i++) begin
      if (s2_q[i] == pins_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= len_m1_s) begin
        pins_d[i] = s2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = s2_q[i];
        fall_d[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DB_ONE;
      end
    end
  end

  // An enabled event keeps its pending bit set both on the accepting edge and while
  // the pulse is visible, so a clear strobe overlapping the event never loses it.
  always_comb begin
    pending_d = (pending_q & ~irq_clr_i)
              | (rise_d & rise_en_i) | (fall_d & fall_en_i)
              | (rise_q & rise_en_i) | (fall_q & fall_en_i);
    irq_d     = |pending_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cnt_q     <= '0;
      pins_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      s1_q      <= pins_i;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      pins_q    <= pins_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign pins_o    = pins_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = pending_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed, table-driven bench for gpio_input_conditioner with hand-computed expectations.
module tb_gpio_input_conditioner;

  logic        clk;
  logic        rst;
  logic [31:0] pins_i;
  logic [7:0]  len_i;
  logic [31:0] ren_i;
  logic [31:0] fen_i;
  logic [31:0] clr_i;
  logic [31:0] pins_o;
  logic [31:0] rise_o;
  logic [31:0] fall_o;
  logic [31:0] pend_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  gpio_input_conditioner #(.G_NUM_PINS(32), .G_DB_BITS(8)) dut (
    .wb_clk_i(clk), .rst_i(rst), .pins_i(pins_i), .debounce_len_i(len_i),
    .rise_en_i(ren_i), .fall_en_i(fen_i), .irq_clr_i(clr_i),
    .pins_o(pins_o), .rise_o(rise_o), .fall_o(fall_o), .pending_o(pend_o), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pins;
    logic [7:0]  len;
    logic [31:0] ren;
    logic [31:0] fen;
    logic [31:0] clr;
    int          adv;
    bit          every;
    logic [31:0] e_pins;
    logic [31:0] e_rise;
    logic [31:0] e_fall;
    logic [31:0] e_pend;
    logic        e_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ep, input logic [31:0] er,
                           input logic [31:0] ef, input logic [31:0] epd, input logic ei);
    cmp32({tag, ".pins_o"}, pins_o, ep);
    cmp32({tag, ".rise_o"}, rise_o, er);
    cmp32({tag, ".fall_o"}, fall_o, ef);
    cmp32({tag, ".pending_o"}, pend_o, epd);
    cmp32({tag, ".irq_o"}, {31'd0, irq_o}, {31'd0, ei});
  endtask

  task automatic add(input logic [31:0] p, input logic [7:0] l, input logic [31:0] re,
                     input logic [31:0] fe, input logic [31:0] c, input int a, input bit ev,
                     input logic [31:0] ep, input logic [31:0] er, input logic [31:0] ef,
                     input logic [31:0] epd, input logic ei);
    vec_t v;
    v.pins = p; v.len = l; v.ren = re; v.fen = fe; v.clr = c; v.adv = a; v.every = ev;
    v.e_pins = ep; v.e_rise = er; v.e_fall = ef; v.e_pend = epd; v.e_irq = ei;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] exp_p[8];
  logic [31:0] exp_r[8];
  logic [31:0] exp_f[8];

  initial begin
    rst = 1'b1; pins_i = 32'd0; len_i = 8'd1; ren_i = 32'd0; fen_i = 32'd0; clr_i = 32'd0;
    tick();
    tick();
    check_all("reset", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;

    // L=1 latency and rise pulse with enables off.
    add(32'h0000_00A5, 8'd1, 32'd0, 32'd0, 32'd0, 2, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    add(32'h0000_00A5, 8'd1, 32'd0, 32'd0, 32'd0, 1, 1'b0, 32'h0000_00A5, 32'h0000_00A5, 32'd0, 32'd0, 1'b0);
    add(32'h0000_00A5, 8'd1, 32'd0, 32'd0, 32'd0, 3, 1'b1, 32'h0000_00A5, 32'd0, 32'd0, 32'd0, 1'b0);
    add(32'h0000_0000, 8'd1, 32'd0, 32'd0, 32'd0, 3, 1'b0, 32'd0, 32'd0, 32'h0000_00A5, 32'd0, 1'b0);
    add(32'h0000_0000, 8'd1, 32'd0, 32'd0, 32'd0, 2, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    // L=10: a 9-cycle pulse on pin 0 is rejected.
    add(32'h0000_0001, 8'd10, 32'h1, 32'd0, 32'd0, 9, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    add(32'h0000_0000, 8'd10, 32'h1, 32'd0, 32'd0, 14, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    // Held high: accepted at E11 with pending on the same edge, irq one later.
    add(32'h0000_0001, 8'd10, 32'h1, 32'd0, 32'd0, 11, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    add(32'h0000_0001, 8'd10, 32'h1, 32'd0, 32'd0, 1, 1'b0, 32'h1, 32'h1, 32'd0, 32'h1, 1'b0);
    add(32'h0000_0001, 8'd10, 32'h1, 32'd0, 32'd0, 1, 1'b0, 32'h1, 32'd0, 32'd0, 32'h1, 1'b1);
    add(32'h0000_0001, 8'd10, 32'h1, 32'd0, 32'd0, 2, 1'b1, 32'h1, 32'd0, 32'd0, 32'h1, 1'b1);
    // Clear strobe, then irq drops one cycle later.
    add(32'h0000_0001, 8'd10, 32'h1, 32'd0, 32'h1, 1, 1'b0, 32'h1, 32'd0, 32'd0, 32'd0, 1'b1);
    add(32'h0000_0001, 8'd10, 32'h1, 32'd0, 32'd0, 1, 1'b0, 32'h1, 32'd0, 32'd0, 32'd0, 1'b0);
    // Pin 31 with L=3: rise ignored (not enabled), fall pending despite overlapping clear.
    add(32'h8000_0001, 8'd3, 32'h1, 32'h8000_0000, 32'd0, 4, 1'b1, 32'h1, 32'd0, 32'd0, 32'd0, 1'b0);
    add(32'h8000_0001, 8'd3, 32'h1, 32'h8000_0000, 32'd0, 1, 1'b0, 32'h8000_0001, 32'h8000_0000, 32'd0, 32'd0, 1'b0);
    add(32'h0000_0001, 8'd3, 32'h1, 32'h8000_0000, 32'd0, 4, 1'b1, 32'h8000_0001, 32'd0, 32'd0, 32'd0, 1'b0);
    add(32'h0000_0001, 8'd3, 32'h1, 32'h8000_0000, 32'h8000_0000, 1, 1'b0, 32'h1, 32'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    add(32'h0000_0001, 8'd3, 32'h1, 32'h8000_0000, 32'h8000_0000, 1, 1'b0, 32'h1, 32'd0, 32'd0, 32'h8000_0000, 1'b1);
    add(32'h0000_0001, 8'd3, 32'h1, 32'h8000_0000, 32'd0, 3, 1'b1, 32'h1, 32'd0, 32'd0, 32'h8000_0000, 1'b1);
    // Disabling the enable leaves the pending bit alone.
    add(32'h0000_0001, 8'd3, 32'h1, 32'd0, 32'd0, 2, 1'b1, 32'h1, 32'd0, 32'd0, 32'h8000_0000, 1'b1);
    add(32'h0000_0001, 8'd3, 32'h1, 32'd0, 32'h8000_0000, 1, 1'b0, 32'h1, 32'd0, 32'd0, 32'd0, 1'b1);
    add(32'h0000_0001, 8'd3, 32'h1, 32'd0, 32'd0, 1, 1'b0, 32'h1, 32'd0, 32'd0, 32'd0, 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      pins_i = vecs[k].pins; len_i = vecs[k].len; ren_i = vecs[k].ren;
      fen_i = vecs[k].fen; clr_i = vecs[k].clr;
      for (int c = 0; c < vecs[k].adv; c++) begin
        tick();
        if (vecs[k].every || c == vecs[k].adv - 1)
          check_all($sformatf("vec%0d.c%0d", k, c), vecs[k].e_pins, vecs[k].e_rise,
                    vecs[k].e_fall, vecs[k].e_pend, vecs[k].e_irq);
      end
    end
    clr_i = 32'd0;

    // Reset partway through a 20-cycle debounce on pin 5 discards the count.
    pins_i = 32'h0000_0020; len_i = 8'd20; ren_i = 32'd0; fen_i = 32'd0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    check_all("midrst", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 21; c++) begin
      tick();
      check_all($sformatf("postrst.c%0d", c), 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    end
    tick();
    check_all("postrst.accept", 32'h20, 32'h20, 32'd0, 32'd0, 1'b0);
    tick();
    check_all("postrst.after", 32'h20, 32'd0, 32'd0, 32'd0, 1'b0);

    // Debounce length 0 must behave exactly like length 1.
    for (int k = 0; k < 8; k++) begin
      exp_p[k] = (k < 2) ? 32'd0 : ((k < 6) ? 32'h3 : 32'h1);
      exp_r[k] = (k == 2) ? 32'h3 : 32'd0;
      exp_f[k] = (k == 6) ? 32'h2 : 32'd0;
    end
    for (int l = 0; l < 2; l++) begin
      pins_i = 32'd0; len_i = 8'(l);
      do_reset();
      pins_i = 32'h3;
      for (int k = 0; k < 8; k++) begin
        if (k == 4) pins_i = 32'h1;
        tick();
        check_all($sformatf("len%0d.k%0d", l, k), exp_p[k], exp_r[k], exp_f[k], 32'd0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
